// File: rtl/jesd204_lfsr_pkg.sv
// rtl/jesd204_lfsr_pkg.sv - shared types and polynomial constants for the JESD204 lane scrambler
// Contents:
//   lfsr_mode_e    scramble / descramble selector
//   JESD204C_POLY  x^58 + x^39 + 1, bit k-1 set for a tap at s[n-k]
//   PRBS*_POLY     common PRBS generator polynomials in the same tap encoding
package jesd204_lfsr_pkg;

  typedef enum logic {
    LFSR_SCRAMBLE   = 1'b0,
    LFSR_DESCRAMBLE = 1'b1
  } lfsr_mode_e;

  localparam int JESD204C_WIDTH = 58;

  // Taps at s[n-58] and s[n-39].
  localparam logic [57:0] JESD204C_POLY = (58'd1 << 57) | (58'd1 << 38);

  localparam logic [6:0]  PRBS7_POLY  = 7'h60;         // x^7  + x^6  + 1
  localparam logic [8:0]  PRBS9_POLY  = 9'h110;        // x^9  + x^5  + 1
  localparam logic [14:0] PRBS15_POLY = 15'h6000;      // x^15 + x^14 + 1
  localparam logic [22:0] PRBS23_POLY = 23'h420000;    // x^23 + x^18 + 1
  localparam logic [30:0] PRBS31_POLY = 31'h48000000;  // x^31 + x^28 + 1

endpackage

// File: rtl/jesd204_lfsr_lane.sv
// rtl/jesd204_lfsr_lane.sv - one lane of the self-synchronous LFSR scrambler/descrambler
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   mode          0 = scramble, 1 = descramble
//   bypass        output equals input, state still advances
//   state_reset   reload RESET_VAL and clear the bit counter
//   accept        beat handshake completed this cycle
//   in_cnt        bits in beat minus 1
//   in_data       lane input bits, bit 0 first in time
//   out_data      combinational processed bits, bits above in_cnt are 0
//   lock_next     lock flag the top registers alongside this beat
module jesd204_lfsr_lane
  import jesd204_lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH      = 58,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLYNOMIAL = JESD204C_POLY,
  parameter logic [LFSR_WIDTH-1:0] RESET_VAL       = {LFSR_WIDTH{1'b1}},
  parameter int                    DATA_WIDTH      = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic                          bypass,
  input  logic                          state_reset,
  input  logic                          accept,
  input  logic [$clog2(DATA_WIDTH)-1:0] in_cnt,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          lock_next
);

  localparam int LCNT_W = $clog2(LFSR_WIDTH + DATA_WIDTH + 1);

  lfsr_mode_e              lane_mode;
  logic [LFSR_WIDTH-1:0]   state;
  logic [LFSR_WIDTH-1:0]   step_state;
  logic [LCNT_W-1:0]       bit_cnt;
  logic [LCNT_W-1:0]       base_cnt;
  logic [LCNT_W-1:0]       sum_cnt;
  logic [LCNT_W-1:0]       cnt_next;
  logic                    tap;
  logic                    fb;

  assign lane_mode = lfsr_mode_e'(mode);

  // state[k-1] holds s[n-k]; each processed bit shifts in at state[0].
  // A state_reset arriving with a beat makes that beat start from RESET_VAL.
  always_comb begin
    step_state = state_reset ? RESET_VAL : state;
    out_data   = '0;
    tap        = 1'b0;
    fb         = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i <= int'(in_cnt)) begin
        tap         = ^(step_state & LFSR_POLYNOMIAL);
        out_data[i] = bypass ? in_data[i] : (in_data[i] ^ tap);
        // Scrambler feeds back its own output; descrambler feeds back the line bit.
        fb          = (lane_mode == LFSR_DESCRAMBLE) ? in_data[i] : (in_data[i] ^ tap);
        step_state  = {step_state[LFSR_WIDTH-2:0], fb};
      end
    end
  end

  // Saturating count of absorbed bits; saturating at LFSR_WIDTH keeps it from wrapping.
  always_comb begin
    base_cnt  = state_reset ? '0 : bit_cnt;
    sum_cnt   = base_cnt + LCNT_W'(in_cnt) + LCNT_W'(1);
    cnt_next  = (sum_cnt >= LCNT_W'(LFSR_WIDTH)) ? LCNT_W'(LFSR_WIDTH) : sum_cnt;
    lock_next = (lane_mode == LFSR_DESCRAMBLE) && (cnt_next >= LCNT_W'(LFSR_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET_VAL;
      bit_cnt <= '0;
    end else if (accept) begin
      state   <= step_state;
      bit_cnt <= cnt_next;
    end else if (state_reset) begin
      state   <= RESET_VAL;
      bit_cnt <= '0;
    end
  end

endmodule

// File: rtl/jesd204_lfsr_multilane.sv
// rtl/jesd204_lfsr_multilane.sv - multi-lane JESD204 LFSR scrambler/descrambler with valid/ready
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mode                     0 = scramble, 1 = descramble (change only while idle)
//   bypass                   out data = in data, state still advances
//   state_reset              reload all lane states, clear lock
//   in_valid/in_ready        input beat handshake
//   in_cnt, in_data          bits-per-beat minus 1, lane l at [l*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready      output beat handshake (one-entry output register)
//   out_cnt, out_data        presented beat, bits above out_cnt are 0
//   locked                   per-lane descrambler lock
module jesd204_lfsr_multilane
  import jesd204_lfsr_pkg::*;
#(
  parameter int                    NUM_LANES       = 4,
  parameter int                    LFSR_WIDTH      = 58,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLYNOMIAL = JESD204C_POLY,
  parameter logic [LFSR_WIDTH-1:0] RESET_VAL       = {LFSR_WIDTH{1'b1}},
  parameter int                    DATA_WIDTH      = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mode,
  input  logic                            bypass,
  input  logic                            state_reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [$clog2(DATA_WIDTH)-1:0]   in_cnt,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(DATA_WIDTH)-1:0]   out_cnt,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            locked
);

  logic                            accept;
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_out;
  logic [NUM_LANES-1:0]            lock_next;

  // The output register can take a new beat when empty or being drained this cycle.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    jesd204_lfsr_lane #(
      .LFSR_WIDTH      (LFSR_WIDTH),
      .LFSR_POLYNOMIAL (LFSR_POLYNOMIAL),
      .RESET_VAL       (RESET_VAL),
      .DATA_WIDTH      (DATA_WIDTH)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .bypass      (bypass),
      .state_reset (state_reset),
      .accept      (accept),
      .in_cnt      (in_cnt),
      .in_data     (in_data[l*DATA_WIDTH +: DATA_WIDTH]),
      .out_data    (lane_out[l*DATA_WIDTH +: DATA_WIDTH]),
      .lock_next   (lock_next[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_data  <= '0;
      locked    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_cnt   <= in_cnt;
      out_data  <= lane_out;
      locked    <= lock_next;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A lone state_reset clears lock immediately; the presented beat stays put.
      if (state_reset) begin
        locked <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jesd204_lfsr_multilane.sv
// tb/tb_jesd204_lfsr_multilane.sv - scoreboard bench for jesd204_lfsr_multilane
module tb_jesd204_lfsr_multilane;

  localparam int NL = 4;
  localparam int W  = 58;
  localparam int DW = 64;
  localparam int BW = NL * DW;

  typedef struct {
    logic [BW-1:0] data;
    logic [5:0]    cnt;
    logic [NL-1:0] lk;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          bypass = 1'b0;
  logic          state_reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [5:0]    in_cnt = '0;
  logic [BW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [5:0]    out_cnt;
  logic [BW-1:0] out_data;
  logic [NL-1:0] locked;

  logic          dsc_in_valid;
  logic          dsc_in_ready;
  logic          dsc_out_valid;
  logic [5:0]    dsc_out_cnt;
  logic [BW-1:0] dsc_out_data;
  logic [NL-1:0] dsc_locked;

  beat_t         q[$];
  logic [BW-1:0] dq[$];
  logic [BW-1:0] cap[$];
  logic          cap_en = 1'b0;
  logic          chk_dsc = 1'b0;
  int            dbeat = 0;
  int            checks = 0;
  int            errors = 0;

  logic [W-1:0]  m_st[NL];
  int            m_cnt[NL];
  logic [W-1:0]  m_rv = '0;

  always #5 clk = ~clk;

  jesd204_lfsr_multilane #(.RESET_VAL('0)) dut (
    .clk(clk), .rst(rst), .mode(mode), .bypass(bypass), .state_reset(state_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt), .out_data(out_data),
    .locked(locked)
  );

  assign dsc_in_valid = out_valid & out_ready;

  jesd204_lfsr_multilane dsc (
    .clk(clk), .rst(rst), .mode(1'b1), .bypass(1'b0), .state_reset(1'b0),
    .in_valid(dsc_in_valid), .in_ready(dsc_in_ready), .in_cnt(out_cnt), .in_data(out_data),
    .out_valid(dsc_out_valid), .out_ready(1'b1), .out_cnt(dsc_out_cnt), .out_data(dsc_out_data),
    .locked(dsc_locked)
  );

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_st[l]  = m_rv;
      m_cnt[l] = 0;
    end
  endtask

  // Bit-serial reference for x^58 + x^39 + 1: s[0] is the newest bit.
  function automatic beat_t model_beat(input logic [BW-1:0] d, input int cnt, input logic byp);
    beat_t        r;
    logic [W-1:0] s;
    logic         di;
    logic         t;
    logic         o;
    r.data = '0;
    r.cnt  = cnt[5:0];
    r.lk   = '0;
    for (int l = 0; l < NL; l++) begin
      s = m_st[l];
      for (int b = 0; b <= cnt; b++) begin
        di = d[l*DW + b];
        t  = s[57] ^ s[38];
        o  = di ^ t;
        r.data[l*DW + b] = byp ? di : o;
        s = {s[W-2:0], (mode ? di : o)};
      end
      m_st[l]  = s;
      m_cnt[l] = m_cnt[l] + cnt + 1;
      if (m_cnt[l] > W) m_cnt[l] = W;
      r.lk[l] = mode && (m_cnt[l] >= W);
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd_bus();
    logic [BW-1:0] r;
    for (int k = 0; k < BW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [BW-1:0] d, input int cnt, input logic byp, input logic sr);
    int    n;
    beat_t e;
    n = 0;
    in_data = d; in_cnt = cnt[5:0]; bypass = byp; state_reset = sr; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", BW'(in_ready), BW'(1));
    if (in_ready) begin
      if (sr) model_reset();
      e = model_beat(d, cnt, byp);
      q.push_back(e);
      if (chk_dsc) dq.push_back(d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; bypass = 1'b0; state_reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() + dq.size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("drain", BW'(q.size() + dq.size()), '0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; state_reset = 1'b0; bypass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    dq.delete();
    model_reset();
  endtask

  always @(negedge clk) begin : mon
    beat_t         e;
    logic [BW-1:0] exp;
    logic [BW-1:0] mask;
    if (!rst && out_valid && out_ready) begin
      check("sb_nonempty", BW'(q.size() > 0), BW'(1));
      if (q.size() > 0) begin
        e = q.pop_front();
        check("out_data", out_data, e.data);
        check("out_cnt", BW'(out_cnt), BW'(e.cnt));
        check("locked", BW'(locked), BW'(e.lk));
        if (cap_en) cap.push_back(out_data);
      end
    end
    if (!rst && chk_dsc && dsc_out_valid) begin
      check("dsc_nonempty", BW'(dq.size() > 0), BW'(1));
      if (dq.size() > 0) begin
        exp  = dq.pop_front();
        mask = '1;
        if (dbeat == 0) begin
          for (int l = 0; l < NL; l++) mask[l*DW +: W] = '0;
        end
        check("dsc_data", (dsc_out_data ^ exp) & mask, '0);
        check("dsc_locked", BW'(dsc_locked), BW'(4'hf));
        dbeat++;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    logic [BW-1:0] d;
    logic [BW-1:0] w;
    logic [BW-1:0] p;
    logic [BW-1:0] capa[$];
    logic [DW-1:0] cat;

    // Reset state
    model_reset();
    do_reset();
    @(negedge clk);
    check("rst_out_valid", BW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_cnt", BW'(out_cnt), '0);
    check("rst_locked", BW'(locked), '0);
    check("rst_in_ready", BW'(in_ready), BW'(1));
    @(posedge clk); #1;

    // 1: zero data, zero seed, scramble -> all zero, unlocked
    mode = 1'b0;
    for (int j = 0; j < 4; j++) send('0, 63, 1'b0, 1'b0);
    drain();

    // 2: scrambler (seed 0) into descrambler (seed ones)
    do_reset();
    dbeat = 0;
    chk_dsc = 1'b1;
    for (int j = 0; j < 6; j++) begin
      for (int l = 0; l < NL; l++) d[l*DW +: DW] = 64'h0123_4567_89ab_cdef + 64'(j * NL + l);
      send(d, 63, 1'b0, 1'b0);
    end
    drain();
    chk_dsc = 1'b0;
    check("t2_dsc_beats", BW'(dbeat), BW'(6));

    // 3: eight 8-bit beats versus one 64-bit beat, descramble mode
    do_reset();
    mode = 1'b1;
    w = rnd_bus();
    p = rnd_bus();
    cap.delete();
    cap_en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      d = '0;
      for (int l = 0; l < NL; l++) d[l*DW +: 8] = w[l*DW + 8*j +: 8];
      send(d, 7, 1'b0, 1'b0);
    end
    send(p, 63, 1'b0, 1'b0);
    drain();
    capa = cap;
    cap.delete();
    do_reset();
    send(w, 63, 1'b0, 1'b0);
    send(p, 63, 1'b0, 1'b0);
    drain();
    cap_en = 1'b0;
    check("t3_short_beats", BW'(capa.size()), BW'(9));
    check("t3_long_beats", BW'(cap.size()), BW'(2));
    if (capa.size() == 9 && cap.size() == 2) begin
      for (int l = 0; l < NL; l++) begin
        for (int j = 0; j < 8; j++) cat[8*j +: 8] = capa[j][l*DW +: 8];
        check("t3_concat", BW'(cat), BW'(cap[0][l*DW +: DW]));
      end
      check("t3_final_state", capa[8], cap[1]);
    end

    // 4: back-pressure for 5 cycles, then bypass beat
    do_reset();
    mode = 1'b0;
    out_ready = 1'b0;
    send(rnd_bus(), 63, 1'b0, 1'b0);
    fork
      send(rnd_bus(), 63, 1'b0, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("t4_in_ready", BW'(in_ready), '0);
          check("t4_hold", out_data, q[0].data);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    send(rnd_bus(), 63, 1'b1, 1'b0);
    send(rnd_bus(), 63, 1'b0, 1'b0);
    drain();

    // 5: state_reset with accept on beat 3, then a lone state_reset
    do_reset();
    mode = 1'b1;
    for (int j = 0; j < 6; j++) send(rnd_bus(), 31, 1'b0, (j == 3));
    drain();
    @(negedge clk);
    check("t5_locked_before", BW'(locked), BW'(4'hf));
    @(posedge clk); #1;
    state_reset = 1'b1;
    @(posedge clk); #1;
    state_reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("t5_sr_locked", BW'(locked), '0);
    check("t5_sr_out_valid", BW'(out_valid), '0);
    @(posedge clk); #1;
    send(rnd_bus(), 31, 1'b0, 1'b0);
    send(rnd_bus(), 31, 1'b0, 1'b0);
    drain();

    // 6: rst while a beat is stalled on the output
    do_reset();
    mode = 1'b1;
    send(rnd_bus(), 63, 1'b0, 1'b0);
    send(rnd_bus(), 63, 1'b0, 1'b0);
    drain();
    out_ready = 1'b0;
    send(rnd_bus(), 63, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_pending", BW'(out_valid), BW'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    model_reset();
    @(negedge clk);
    check("t6_out_valid", BW'(out_valid), '0);
    check("t6_locked", BW'(locked), '0);
    check("t6_out_data", out_data, '0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) send(rnd_bus(), 63, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
